// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the branch checkpoint queue.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int HISTORY_BITS_DEFAULT = 8;
    localparam int PC_STEP              = 4;

    // ghr is stored at the predictor's fixed history width.
    typedef struct packed {
        logic [31:0]                     pc;
        logic                            pred_taken;
        logic [31:0]                     pred_target;
        logic [HISTORY_BITS_DEFAULT-1:0] ghr;
    } bp_checkpoint_t;

    // True when tag was allocated after ref_tag, ages measured from head (mod depth).
    function automatic logic is_younger(input int tag, input int ref_tag,
                                        input int head, input int depth);
        int tag_age;
        int ref_age;
        tag_age = (tag - head) & (depth - 1);
        ref_age = (ref_tag - head) & (depth - 1);
        return tag_age > ref_age;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_checkpoint_queue
// Description : Records predicted branches at fetch, checks them at resolve,
//               trains/recovers the predictor and squashes wrong-path entries.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_checkpoint_queue
    import bp_pkg::*;
#(
    parameter int  DEPTH        = 8,
    parameter int  HISTORY_BITS = HISTORY_BITS_DEFAULT,
    localparam int TAG_BITS     = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    alloc_valid,
    input  logic [31:0]             alloc_pc,
    input  logic                    alloc_pred_taken,
    input  logic [31:0]             alloc_pred_target,
    input  logic [HISTORY_BITS-1:0] alloc_ghr,
    output logic                    alloc_ready,
    output logic [TAG_BITS-1:0]     alloc_tag,

    input  logic                    resolve_valid,
    input  logic [TAG_BITS-1:0]     resolve_tag,
    input  logic                    resolve_taken,
    input  logic [31:0]             resolve_target,

    output logic                    update_en,
    output logic [31:0]             update_pc,
    output logic                    update_taken,
    output logic [31:0]             update_target,
    output logic                    mispredict,
    output logic [HISTORY_BITS-1:0] recover_ghr,
    output logic [TAG_BITS:0]       count
);

    localparam int                    c_ptr_bits = TAG_BITS + 1;
    localparam logic [c_ptr_bits-1:0] c_ptr_one  = c_ptr_bits'(1);

    logic [c_ptr_bits-1:0] r_head;
    logic [c_ptr_bits-1:0] r_tail;
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_done;
    bp_checkpoint_t        r_entry [DEPTH];

    logic [TAG_BITS-1:0]   w_head_idx;
    logic [TAG_BITS-1:0]   w_tail_idx;
    logic [TAG_BITS-1:0]   w_res_dist;
    logic [c_ptr_bits-1:0] w_squash_tail;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_resolve_ok;
    logic                  w_mispredict_now;
    logic                  w_alloc_fire;
    logic                  w_retire;
    logic [DEPTH-1:0]      w_squash;
    logic [DEPTH-1:0]      w_valid_next;
    logic [DEPTH-1:0]      w_done_next;
    bp_checkpoint_t        w_res_entry;
    bp_checkpoint_t        w_alloc_entry;

    assign w_head_idx = r_head[TAG_BITS-1:0];
    assign w_tail_idx = r_tail[TAG_BITS-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAG_BITS] != r_tail[TAG_BITS]);

    assign w_res_entry      = r_entry[resolve_tag];
    assign w_resolve_ok     = resolve_valid && r_valid[resolve_tag] && !r_done[resolve_tag];
    assign w_mispredict_now = w_resolve_ok &&
                              ((resolve_taken != w_res_entry.pred_taken) ||
                               (resolve_taken && (resolve_target != w_res_entry.pred_target)));

    assign alloc_ready  = !w_full && !w_mispredict_now;
    assign alloc_tag    = w_tail_idx;
    assign count        = r_tail - r_head;
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_retire     = !w_empty && r_valid[w_head_idx] && r_done[w_head_idx];

    // New tail sits just past the mispredicting entry; adding its age to head
    // yields the correct wrap bit.
    assign w_res_dist    = resolve_tag - w_head_idx;
    assign w_squash_tail = r_head + {1'b0, w_res_dist} + c_ptr_one;

    always_comb begin
        w_alloc_entry             = '0;
        w_alloc_entry.pc          = alloc_pc;
        w_alloc_entry.pred_taken  = alloc_pred_taken;
        w_alloc_entry.pred_target = alloc_pred_target;
        w_alloc_entry.ghr         = HISTORY_BITS_DEFAULT'(alloc_ghr);
    end

    always_comb begin
        w_squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_squash[i] = w_mispredict_now &&
                          is_younger(i, int'(resolve_tag), int'(w_head_idx), DEPTH);
        end
    end

    always_comb begin
        w_valid_next = r_valid & ~w_squash;
        w_done_next  = r_done & ~w_squash;
        if (w_retire) begin
            w_valid_next[w_head_idx] = 1'b0;
            w_done_next[w_head_idx]  = 1'b0;
        end
        if (w_resolve_ok) begin
            w_done_next[resolve_tag] = 1'b1;
        end
        if (w_alloc_fire) begin
            w_valid_next[w_tail_idx] = 1'b1;
            w_done_next[w_tail_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            if (w_retire) begin
                r_head <= r_head + c_ptr_one;
            end
            if (w_mispredict_now) begin
                r_tail <= w_squash_tail;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + c_ptr_one;
            end
        end
    end

    // Payload is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (w_alloc_fire) begin
            r_entry[w_tail_idx] <= w_alloc_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            update_en     <= 1'b0;
            mispredict    <= 1'b0;
            update_pc     <= '0;
            update_taken  <= 1'b0;
            update_target <= '0;
            recover_ghr   <= '0;
        end else begin
            update_en  <= w_resolve_ok;
            mispredict <= w_mispredict_now;
            if (w_resolve_ok) begin
                update_pc     <= w_res_entry.pc;
                update_taken  <= resolve_taken;
                update_target <= resolve_taken ? resolve_target
                                               : (w_res_entry.pc + 32'(PC_STEP));
                recover_ghr   <= HISTORY_BITS'(w_res_entry.ghr);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_checkpoint_queue
// Description : Table vectors, directed corner sequences and random traffic
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_queue;

    localparam int DEPTH = 8;
    localparam int HB    = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pred_target;
    logic [7:0]  alloc_ghr;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        mispredict;
    logic [7:0]  recover_ghr;
    logic [3:0]  count;

    always #5 clock = ~clock;

    branch_checkpoint_queue #(.DEPTH(DEPTH), .HISTORY_BITS(HB)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
        .alloc_pred_target(alloc_pred_target), .alloc_ghr(alloc_ghr),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .mispredict(mispredict),
        .recover_ghr(recover_ghr), .count(count)
    );

    typedef struct packed {
        logic        av;
        logic [31:0] apc;
        logic        apt;
        logic [31:0] aptgt;
        logic [7:0]  aghr;
        logic        rv;
        logic [2:0]  rtag;
        logic        rtk;
        logic [31:0] rtgt;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_rdy;
        logic [2:0]  e_tag;
        logic [3:0]  e_cnt;
        logic        e_en;
        logic        e_mis;
        logic [31:0] e_pc;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [7:0]  e_ghr;
    } row_t;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic [7:0]  ghr;
        bit          done;
    } ment_t;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: live checkpoints oldest-first, plus the next tag to hand out.
    ment_t       mq[$];
    int          m_next_tag;
    logic        e_en, e_mis, e_tk;
    logic [31:0] e_pc, e_tgt;
    logic [7:0]  e_ghr;

    row_t tbl[23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        alloc_valid       = s.av;
        alloc_pc          = s.apc;
        alloc_pred_taken  = s.apt;
        alloc_pred_target = s.aptgt;
        alloc_ghr         = s.aghr;
        resolve_valid     = s.rv;
        resolve_tag       = s.rtag;
        resolve_taken     = s.rtk;
        resolve_target    = s.rtgt;
    endtask

    function automatic stim_t mk_alloc(input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt, input logic [7:0] ghr);
        stim_t s;
        s = '0;
        s.av = 1'b1; s.apc = pc; s.apt = tk; s.aptgt = tgt; s.aghr = ghr;
        return s;
    endfunction

    function automatic stim_t mk_res(input logic [2:0] tag, input logic tk, input logic [31:0] tgt);
        stim_t s;
        s = '0;
        s.rv = 1'b1; s.rtag = tag; s.rtk = tk; s.rtgt = tgt;
        return s;
    endfunction

    function automatic row_t mk_row(
        input logic [31:0] av, input logic [31:0] apc, input logic [31:0] apt,
        input logic [31:0] aptgt, input logic [31:0] aghr,
        input logic [31:0] rv, input logic [31:0] rtag, input logic [31:0] rtk, input logic [31:0] rtgt,
        input logic [31:0] rdy, input logic [31:0] tag, input logic [31:0] cnt,
        input logic [31:0] en, input logic [31:0] mis, input logic [31:0] pc,
        input logic [31:0] tk, input logic [31:0] tgt, input logic [31:0] ghr);
        row_t r;
        r.s.av = av[0]; r.s.apc = apc; r.s.apt = apt[0]; r.s.aptgt = aptgt; r.s.aghr = aghr[7:0];
        r.s.rv = rv[0]; r.s.rtag = rtag[2:0]; r.s.rtk = rtk[0]; r.s.rtgt = rtgt;
        r.e_rdy = rdy[0]; r.e_tag = tag[2:0]; r.e_cnt = cnt[3:0];
        r.e_en = en[0]; r.e_mis = mis[0]; r.e_pc = pc; r.e_tk = tk[0]; r.e_tgt = tgt; r.e_ghr = ghr[7:0];
        return r;
    endfunction

    task automatic apply_row(input int i, input row_t r);
        drive(r.s);
        #1;
        check($sformatf("row%0d alloc_ready", i), 64'(alloc_ready), 64'(r.e_rdy));
        check($sformatf("row%0d alloc_tag", i), 64'(alloc_tag), 64'(r.e_tag));
        check($sformatf("row%0d count", i), 64'(count), 64'(r.e_cnt));
        @(posedge clock); #1;
        check($sformatf("row%0d update_en", i), 64'(update_en), 64'(r.e_en));
        check($sformatf("row%0d mispredict", i), 64'(mispredict), 64'(r.e_mis));
        check($sformatf("row%0d update_pc", i), 64'(update_pc), 64'(r.e_pc));
        check($sformatf("row%0d update_taken", i), 64'(update_taken), 64'(r.e_tk));
        check($sformatf("row%0d update_target", i), 64'(update_target), 64'(r.e_tgt));
        check($sformatf("row%0d recover_ghr", i), 64'(recover_ghr), 64'(r.e_ghr));
    endtask

    task automatic model_clear();
        mq.delete();
        m_next_tag = 0;
        e_en = 1'b0; e_mis = 1'b0; e_tk = 1'b0;
        e_pc = '0; e_tgt = '0; e_ghr = '0;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        drive('0);
        @(posedge clock); #1;
        check({name, " count"}, 64'(count), 64'(0));
        check({name, " alloc_tag"}, 64'(alloc_tag), 64'(0));
        check({name, " update_en"}, 64'(update_en), 64'(0));
        check({name, " mispredict"}, 64'(mispredict), 64'(0));
        check({name, " update_pc"}, 64'(update_pc), 64'(0));
        check({name, " recover_ghr"}, 64'(recover_ghr), 64'(0));
        reset = 1'b0;
        model_clear();
    endtask

    task automatic cyc_model(input stim_t s);
        int    idx;
        bit    acc, mis, rdy, ret;
        ment_t m;
        drive(s);
        #1;
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == int'(s.rtag) && !mq[i].done) idx = i;
        acc = s.rv && (idx >= 0);
        mis = acc && ((s.rtk != mq[idx].pt) || (s.rtk && s.rtgt != mq[idx].ptgt));
        rdy = (mq.size() < DEPTH) && !mis;
        check("alloc_ready", 64'(alloc_ready), 64'(rdy));
        check("alloc_tag", 64'(alloc_tag), 64'(m_next_tag));
        check("count", 64'(count), 64'(mq.size()));
        ret   = (mq.size() > 0) && mq[0].done;
        e_en  = acc;
        e_mis = mis;
        if (acc) begin
            e_pc  = mq[idx].pc;
            e_tk  = s.rtk;
            e_tgt = s.rtk ? s.rtgt : mq[idx].pc + 32'd4;
            e_ghr = mq[idx].ghr;
            mq[idx].done = 1'b1;
            if (mis) begin
                while (mq.size() > idx + 1) void'(mq.pop_back());
                m_next_tag = (int'(s.rtag) + 1) % DEPTH;
            end
        end
        if (s.av && rdy) begin
            m.tag = m_next_tag; m.pc = s.apc; m.pt = s.apt; m.ptgt = s.aptgt;
            m.ghr = s.aghr; m.done = 1'b0;
            mq.push_back(m);
            m_next_tag = (m_next_tag + 1) % DEPTH;
        end
        if (ret) void'(mq.pop_front());
        @(posedge clock); #1;
        check("update_en", 64'(update_en), 64'(e_en));
        check("mispredict", 64'(mispredict), 64'(e_mis));
        check("update_pc", 64'(update_pc), 64'(e_pc));
        check("update_taken", 64'(update_taken), 64'(e_tk));
        check("update_target", 64'(update_target), 64'(e_tgt));
        check("recover_ghr", 64'(recover_ghr), 64'(e_ghr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        int    k;
        reset = 1'b1;
        drive('0);
        do_reset("por");

        // Hand-derived cycles: matching resolves, a direction mispredict, and a squash.
        tbl[0]  = mk_row(1,'h100,1,'h180,'h11, 0,0,0,0,     1,0,0, 0,0,0,0,0,0);
        tbl[1]  = mk_row(1,'h200,1,'h280,'h22, 0,0,0,0,     1,1,1, 0,0,0,0,0,0);
        tbl[2]  = mk_row(1,'h300,0,'h304,'h33, 0,0,0,0,     1,2,2, 0,0,0,0,0,0);
        tbl[3]  = mk_row(0,0,0,0,0, 1,0,1,'h180,            1,3,3, 1,0,'h100,1,'h180,'h11);
        tbl[4]  = mk_row(0,0,0,0,0, 1,1,1,'h280,            1,3,3, 1,0,'h200,1,'h280,'h22);
        tbl[5]  = mk_row(0,0,0,0,0, 1,2,0,'hDEAD,           1,3,2, 1,0,'h300,0,'h304,'h33);
        tbl[6]  = mk_row(0,0,0,0,0, 0,0,0,0,                1,3,1, 0,0,'h300,0,'h304,'h33);
        tbl[7]  = mk_row(0,0,0,0,0, 0,0,0,0,                1,3,0, 0,0,'h300,0,'h304,'h33);
        tbl[8]  = mk_row(1,'h100,0,'h104,'hA5, 0,0,0,0,     1,3,0, 0,0,'h300,0,'h304,'h33);
        tbl[9]  = mk_row(0,0,0,0,0, 1,3,1,'h400,            0,4,1, 1,1,'h100,1,'h400,'hA5);
        tbl[10] = mk_row(0,0,0,0,0, 0,0,0,0,                1,4,1, 0,0,'h100,1,'h400,'hA5);
        tbl[11] = mk_row(0,0,0,0,0, 0,0,0,0,                1,4,0, 0,0,'h100,1,'h400,'hA5);
        tbl[12] = mk_row(1,'h500,1,'h540,'h01, 0,0,0,0,     1,4,0, 0,0,'h100,1,'h400,'hA5);
        tbl[13] = mk_row(1,'h600,1,'h640,'h02, 0,0,0,0,     1,5,1, 0,0,'h100,1,'h400,'hA5);
        tbl[14] = mk_row(1,'h700,1,'h740,'h03, 0,0,0,0,     1,6,2, 0,0,'h100,1,'h400,'hA5);
        tbl[15] = mk_row(1,'h800,1,'h840,'h04, 0,0,0,0,     1,7,3, 0,0,'h100,1,'h400,'hA5);
        tbl[16] = mk_row(1,'h999,1,'h9C0,'h55, 1,5,0,0,     0,0,4, 1,1,'h600,0,'h604,'h02);
        tbl[17] = mk_row(0,0,0,0,0, 1,7,1,'h840,            1,6,2, 0,0,'h600,0,'h604,'h02);
        tbl[18] = mk_row(0,0,0,0,0, 1,6,1,'h740,            1,6,2, 0,0,'h600,0,'h604,'h02);
        tbl[19] = mk_row(0,0,0,0,0, 1,4,1,'h540,            1,6,2, 1,0,'h500,1,'h540,'h01);
        tbl[20] = mk_row(0,0,0,0,0, 0,0,0,0,                1,6,2, 0,0,'h500,1,'h540,'h01);
        tbl[21] = mk_row(0,0,0,0,0, 0,0,0,0,                1,6,1, 0,0,'h500,1,'h540,'h01);
        tbl[22] = mk_row(0,0,0,0,0, 0,0,0,0,                1,6,0, 0,0,'h500,1,'h540,'h01);
        for (int i = 0; i < 23; i++) apply_row(i, tbl[i]);

        // Fill, drop while full, resolve head, then allocate into the wrapped slot.
        do_reset("pre_full");
        for (int i = 0; i < DEPTH; i++)
            cyc_model(mk_alloc(32'(32'h1000 + i * 16), 1'b1, 32'(32'h1008 + i * 16), 8'(i)));
        check("full count", 64'(count), 64'(DEPTH));
        check("full ready", 64'(alloc_ready), 64'(0));
        cyc_model(mk_alloc(32'h2000, 1'b1, 32'h2040, 8'h77));
        s = mk_res(3'd0, 1'b1, 32'h1008);
        s.av = 1'b1; s.apc = 32'h2100; s.apt = 1'b0; s.aptgt = 32'h2104;
        cyc_model(s);
        cyc_model(mk_alloc(32'h3000, 1'b0, 32'h3004, 8'h12));
        check("wrap alloc_tag", 64'(alloc_tag), 64'(0));
        cyc_model(mk_alloc(32'h3000, 1'b0, 32'h3004, 8'h12));

        // Out-of-order resolve: head must wait for tags 0 and 1.
        do_reset("pre_ooo");
        for (int i = 0; i < 3; i++)
            cyc_model(mk_alloc(32'(32'h40 * (i + 1)), 1'b0, 32'(32'h40 * (i + 1) + 4), 8'(8'hC0 + i)));
        cyc_model(mk_res(3'd2, 1'b0, 32'h0));
        cyc_model('0);
        cyc_model('0);
        check("ooo head held", 64'(count), 64'(3));
        cyc_model(mk_res(3'd0, 1'b0, 32'h0));
        cyc_model(mk_res(3'd1, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) cyc_model('0);

        // Reset with live entries, then a resolve on a discarded tag.
        for (int i = 0; i < 5; i++)
            cyc_model(mk_alloc(32'(32'h8000 + i * 4), 1'b1, 32'h9000, 8'(i)));
        check("pre-reset count", 64'(count), 64'(5));
        do_reset("mid_reset");
        cyc_model(mk_res(3'd0, 1'b1, 32'h9000));
        cyc_model('0);

        for (int n = 0; n < 2500; n++) begin
            s = '0;
            s.av    = ($urandom_range(9, 0) < 7);
            s.apc   = $urandom & 32'hFFFF_FFFC;
            s.apt   = 1'($urandom_range(1, 0));
            s.aptgt = s.apt ? ($urandom & 32'hFFFF_FFFC) : s.apc + 32'd4;
            s.aghr  = 8'($urandom);
            s.rv    = 1'($urandom_range(1, 0));
            if (mq.size() > 0 && $urandom_range(3, 0) != 0) begin
                k      = int'($urandom_range(mq.size() - 1, 0));
                s.rtag = 3'(mq[k].tag);
                if ($urandom_range(3, 0) != 0) begin
                    s.rtk  = mq[k].pt;
                    s.rtgt = mq[k].ptgt;
                end else begin
                    s.rtk  = 1'($urandom_range(1, 0));
                    s.rtgt = $urandom & 32'hFFFF_FFFC;
                end
            end else begin
                s.rtag = 3'($urandom_range(7, 0));
                s.rtk  = 1'($urandom_range(1, 0));
                s.rtgt = $urandom & 32'hFFFF_FFFC;
            end
            if ($urandom_range(299, 0) == 0) do_reset("rnd_reset");
            else cyc_model(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
